// File: rtl/hazard_stall_ctrl.sv
// Pipeline keep/nop/flush sequencing for load-use, MEM-stage redirects and dmem waits.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_stall_ctrl #(
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned MEM_TIMEOUT      = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_wreg,
    input  logic [1:0] ex_memrw,
    input  logic       mem_branch_taken,
    input  logic       dmem_req,
    input  logic       dmem_ready,
`ifdef HAZARD_PERF_EN
    input  logic        perf_clr,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
`endif
    output logic       keep_pc,
    output logic       keep_ifid,
    output logic       keep_idex,
    output logic       nop_idex,
    output logic       flush_ifid,
    output logic       flush_exmem,
    output logic       keep_exmem,
    output logic       mem_err,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        REDIRECT = 2'b10,
        UNUSED   = 2'b11
    } state_t;

    localparam logic [3:0] RB_W = 4'(REDIRECT_BUBBLES);
    localparam logic [7:0] MT_W = 8'(MEM_TIMEOUT);

    state_t     state;
    logic [3:0] bubble_cnt;
    logic [7:0] wait_cnt;
    logic       load_use;
    logic       mem_stall;

    assign load_use  = (ex_memrw == 2'b10) && (ex_wreg != '0) &&
                       ((id_uses_rs1 && (id_rs1 == ex_wreg)) ||
                        (id_uses_rs2 && (id_rs2 == ex_wreg)));
    assign mem_stall = dmem_req && !dmem_ready;
    assign state_o   = state;

    // Outputs are gated by rst because keep/nop take priority over reset downstream.
    always_comb begin
        keep_pc     = 1'b0;
        keep_ifid   = 1'b0;
        keep_idex   = 1'b0;
        nop_idex    = 1'b0;
        flush_ifid  = 1'b0;
        flush_exmem = 1'b0;
        keep_exmem  = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    if (mem_branch_taken) begin
                        flush_ifid  = 1'b1;
                        nop_idex    = 1'b1;
                        flush_exmem = 1'b1;
                    end else if (mem_stall) begin
                        keep_pc    = 1'b1;
                        keep_ifid  = 1'b1;
                        keep_idex  = 1'b1;
                        keep_exmem = 1'b1;
                    end else if (load_use) begin
                        keep_pc   = 1'b1;
                        keep_ifid = 1'b1;
                        nop_idex  = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_ready && (wait_cnt != MT_W)) begin
                        keep_pc    = 1'b1;
                        keep_ifid  = 1'b1;
                        keep_idex  = 1'b1;
                        keep_exmem = 1'b1;
                    end
                end
                REDIRECT: begin
                    nop_idex = 1'b1;
                    if (mem_branch_taken) begin
                        flush_ifid  = 1'b1;
                        flush_exmem = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            bubble_cnt <= '0;
            wait_cnt   <= '0;
            mem_err    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_branch_taken) begin
                        if (RB_W != '0) begin
                            bubble_cnt <= RB_W;
                            state      <= REDIRECT;
                        end
                    end else if (mem_stall) begin
                        wait_cnt <= 8'd1;
                        state    <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        wait_cnt <= '0;
                        state    <= RUN;
                    end else if (wait_cnt == MT_W) begin
                        mem_err  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                REDIRECT: begin
                    if (mem_branch_taken) begin
                        bubble_cnt <= RB_W;
                    end else begin
                        bubble_cnt <= bubble_cnt - 4'd1;
                        if (bubble_cnt == 4'd1)
                            state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst || perf_clr) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (keep_pc)
                stall_cycles <= stall_cycles + 32'd1;
            if (flush_ifid)
                flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32I core. It generates the per-stage keep (hold) and nop (bubble) controls for the PC, IF/ID, ID/EX (decode stage) and EX/MEM registers. It resolves three conditions:
- load-use hazards,
- taken-branch/jump redirects resolved in MEM,
- multi-cycle data-memory waits, with a timeout.

It sits beside the pipeline registers and is the only driver of their keep/nop inputs.

Parameters:
REDIRECT_BUBBLES, 1, extra cycles nop_idex stays asserted after a redirect to cover imem latency (0..15)
MEM_TIMEOUT, 255, max cycles spent in MEM_WAIT before abort (1..255)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-low reset
id_rs1  input  5  decode-stage rs1 index
id_rs2  input  5  decode-stage rs2 index
id_uses_rs1  input  1  decode instruction reads rs1
id_uses_rs2  input  1  decode instruction reads rs2
ex_wreg  input  5  destination register held in ID/EX
ex_memrw  input  2  ID/EX memory op; 2'b10 = load
mem_branch_taken  input  1  MEM stage resolved a taken branch/jal/jalr
dmem_req  input  1  MEM stage has an active data-memory access
dmem_ready  input  1  data memory completes access this cycle
keep_pc  output  1  hold PC
keep_ifid  output  1  hold IF/ID
keep_idex  output  1  hold ID/EX (decode keep)
nop_idex  output  1  insert bubble into ID/EX (decode nop)
flush_ifid  output  1  squash IF/ID to bubble
flush_exmem  output  1  squash EX/MEM to bubble
keep_exmem  output  1  hold EX/MEM
mem_err  output  1  sticky dmem timeout flag
state_o  output  2  current FSM state (debug)

Behaviour:
Reset and output timing:
- FSM state and counters are registered. Outputs are Mealy: combinational from the current state plus current inputs, so they act in the same cycle the condition is seen.
- While rst=0: state=RUN, bubble_cnt=0, wait_cnt=0, mem_err=0, and every output is 0. Decode gives keep/nop priority over reset, so all-zero outputs here are mandatory.

FSM states: RUN=2'b00, MEM_WAIT=2'b01, REDIRECT=2'b10. 2'b11 is unused and returns to RUN on the next clock.

Priority within RUN is branch > memory wait > load-use:
- mem_branch_taken=1:
  - outputs: flush_ifid=1, nop_idex=1, flush_exmem=1, all keeps=0.
  - if REDIRECT_BUBBLES>0: bubble_cnt<=REDIRECT_BUBBLES, next state REDIRECT; otherwise stay in RUN.
- else dmem_req=1 and dmem_ready=0:
  - outputs: keep_pc=keep_ifid=keep_idex=keep_exmem=1.
  - wait_cnt<=1, next state MEM_WAIT.
- else load-use, defined as ex_memrw==2'b10, ex_wreg!=0, and ((id_uses_rs1 && id_rs1==ex_wreg) or (id_uses_rs2 && id_rs2==ex_wreg)):
  - outputs: keep_pc=keep_ifid=1, nop_idex=1.
  - stay in RUN. The bubble clears the condition on the next cycle, so exactly one stall cycle results.
- otherwise all outputs 0.
- dmem_req=1 with dmem_ready=1 is a single-cycle access: no stall.

MEM_WAIT:
- All four keeps are 1 while dmem_ready=0. wait_cnt increments each cycle.
- dmem_ready=1: keeps are 0 that cycle, next state RUN, wait_cnt<=0.
- wait_cnt==MEM_TIMEOUT with dmem_ready=0: mem_err<=1 (sticky until reset), keeps 0 that cycle, next state RUN.
- mem_branch_taken and the load-use check are ignored in this state. Their stage inputs are held, so they are re-evaluated in RUN afterwards.

REDIRECT:
- nop_idex=1, keep_pc=0. bubble_cnt decrements; at bubble_cnt==1 the next state is RUN.
- A new mem_branch_taken here re-flushes (same outputs as in RUN) and reloads bubble_cnt.

Other rules:
- Register index comparisons are 5-bit equality. x0 never triggers a hazard.
- keep_* and nop_idex are never both asserted for ID/EX.
- A reset asserted mid-stall forces RUN and zero outputs on the next edge.

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds output ports stall_cycles[31:0] and flush_events[31:0], plus input perf_clr.
  - stall_cycles increments every cycle keep_pc=1.
  - flush_events increments on each cycle with flush_ifid=1.
  - Both counters wrap at 2^32, clear on reset or perf_clr=1, and perf_clr wins over a same-cycle increment.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex_memrw=10, ex_wreg=5, id_rs1=5, id_uses_rs1=1 -> exactly one cycle with keep_pc=keep_ifid=nop_idex=1, then all 0. The same stimulus with ex_wreg=0 -> no stall.
- Branch beats load-use: mem_branch_taken=1 plus load-use in the same cycle -> flush_ifid=flush_exmem=nop_idex=1, keep_pc=0. With REDIRECT_BUBBLES=1, one further nop_idex cycle, then RUN.
- Memory wait: dmem_req=1, dmem_ready low for 3 cycles -> keeps=1 for cycles 1-3, 0 on the ready cycle, state_o returns to 00.
- Timeout: MEM_TIMEOUT=4, dmem_ready never rises -> mem_err=1 after the 4th wait cycle, state RUN, mem_err stays 1 until rst=0.
- Reset mid-stall: rst=0 during MEM_WAIT -> the next cycle shows all outputs 0, state_o=00, mem_err=0.
- (HAZARD_PERF_EN) Two load-use stalls plus one branch -> stall_cycles=2, flush_events=1. perf_clr=1 -> both 0.
